practice_sequencer: RTL and testbench

PRACTICE_SEQUENCER -- requirements
Module: practice_sequencer

---
 rtl/practice_sequencer_if.sv | 35 +++
 rtl/practice_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_practice_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/practice_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : practice_sequencer_if
//  Description : Bundles the control, keyboard and display signals of the
//                piano practice sequencer.
//                master modport: the side driving START/MODE/TICK/key_note
//                slave  modport: the sequencer itself
//  Ports       : START, MODE, TICK, key_note       (master -> slave)
//                tone_note, expect_note, Led,
//                busy, done, err_cnt               (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface practice_sequencer_if;
  logic       START;
  logic       MODE;
  logic       TICK;
  logic [3:0] key_note;
  logic [3:0] tone_note;
  logic [3:0] expect_note;
  logic [7:0] Led;
  logic       busy;
  logic       done;
  logic [7:0] err_cnt;

  modport master (
    output START, MODE, TICK, key_note,
    input  tone_note, expect_note, Led, busy, done, err_cnt
  );

  modport slave (
    input  START, MODE, TICK, key_note,
    output tone_note, expect_note, Led, busy, done, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/practice_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : practice_sequencer
//  Description : Piano practice sequencer with a fixed 15-note song.
//                Tutor mode shows the next note and waits for the player to
//                press and release it, counting wrong presses. Autoplay mode
//                drives each note to the tone generator for NOTE_TICKS ticks
//                followed by GAP_TICKS ticks of silence.
//  Ports       : CLK            system clock, rising edge
//                RESET          synchronous active-high reset
//                bus (slave)    START, MODE, TICK, key_note in;
//                               tone_note, expect_note, Led, busy, done,
//                               err_cnt out
//  Options     : PRACTICE_TIMEOUT_EN - when defined, a tutor note left
//                unpressed for TIMEOUT_TICKS ticks counts as an error and the
//                song moves on.
//  Revision    : 1.0  initial release
// ============================================================================
module practice_sequencer #(
  parameter int SONG_LEN      = 15,
  parameter int NOTE_TICKS    = 40,
  parameter int GAP_TICKS     = 10,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic                 CLK,
  input  logic                 RESET,
  practice_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESENT = 3'd1,
    S_RELEASE = 3'd2,
    S_WRONG   = 3'd3,
    S_PLAY    = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int IDX_W  = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int PG_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
`ifdef PRACTICE_TIMEOUT_EN
  // The one tick counter also times the tutor timeout, so size it for that.
  localparam int CNT_MAX = (PG_MAX > TIMEOUT_TICKS) ? PG_MAX : TIMEOUT_TICKS;
`else
  localparam int CNT_MAX = PG_MAX;
`endif
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // The song table has 15 entries; every tick length must be at least one.
  if (SONG_LEN < 1 || SONG_LEN > 15 || NOTE_TICKS < 1 || GAP_TICKS < 1 ||
      TIMEOUT_TICKS < 1) begin : g_param_check
    $error("practice_sequencer: parameter out of range");
  end

  // E E F G G F E D C4 C4 D E E D D  (none=0, C4=1 .. C5=8)
  function automatic logic [3:0] song_at(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       song_at = 4'd3;
      1:       song_at = 4'd3;
      2:       song_at = 4'd4;
      3:       song_at = 4'd5;
      4:       song_at = 4'd5;
      5:       song_at = 4'd4;
      6:       song_at = 4'd3;
      7:       song_at = 4'd2;
      8:       song_at = 4'd1;
      9:       song_at = 4'd1;
      10:      song_at = 4'd2;
      11:      song_at = 4'd3;
      12:      song_at = 4'd3;
      13:      song_at = 4'd2;
      14:      song_at = 4'd2;
      default: song_at = 4'd0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [7:0]         err_q,   err_d;

  logic [3:0]         cur_note;
  logic               is_last;
  logic [7:0]         err_sat;

  assign cur_note = song_at(idx_q);
  assign is_last  = (idx_q == IDX_W'(SONG_LEN - 1));
  assign err_sat  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = '0;
        if (bus.START) begin
          idx_d   = '0;
          err_d   = '0;
          state_d = bus.MODE ? S_PLAY : S_PRESENT;
        end
      end

      S_PRESENT: begin
        // A correct key wins over a timeout landing on the same cycle.
        if (bus.key_note == cur_note) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (bus.key_note != 4'd0) begin
          cnt_d   = '0;
          err_d   = err_sat;
          state_d = S_WRONG;
        end
`ifdef PRACTICE_TIMEOUT_EN
        else if (bus.TICK) begin
          if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
            cnt_d = '0;
            err_d = err_sat;
            if (is_last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_PRESENT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end

      S_RELEASE: begin
        cnt_d = '0;
        if (bus.key_note == 4'd0) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_PRESENT;
          end
        end
      end

      // Waiting for release is what limits errors to one per key press.
      S_WRONG: begin
        cnt_d = '0;
        if (bus.key_note == 4'd0) begin
          state_d = S_PRESENT;
        end
      end

      S_PLAY: begin
        if (bus.TICK) begin
          if (cnt_q == CNT_W'(NOTE_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_GAP: begin
        if (bus.TICK) begin
          if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
            cnt_d = '0;
            if (is_last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_PLAY;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  logic [3:0] expect_w;
  logic [3:0] tone_w;
  logic [7:0] led_w;

  always_comb begin
    expect_w = 4'd0;
    tone_w   = 4'd0;
    case (state_q)
      S_PRESENT, S_RELEASE, S_WRONG, S_GAP: expect_w = cur_note;
      S_PLAY: begin
        expect_w = cur_note;
        tone_w   = cur_note;
      end
      default: ;
    endcase
  end

  // Led[k] lights for note code k+1; note none leaves every bit dark.
  always_comb begin
    led_w = 8'd0;
    for (int k = 0; k < 8; k++) begin
      led_w[k] = (expect_w == 4'(k + 1));
    end
  end

  assign bus.expect_note = expect_w;
  assign bus.tone_note   = tone_w;
  assign bus.Led         = led_w;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.err_cnt     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_practice_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_practice_sequencer
//  Description : Self-checking bench for practice_sequencer (NOTE_TICKS=4,
//                GAP_TICKS=2, TIMEOUT_TICKS=3). Expected notes are queued as
//                stimulus is driven and popped when outputs are sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_practice_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  practice_sequencer_if bus ();

  practice_sequencer #(
    .SONG_LEN      (15),
    .NOTE_TICKS    (4),
    .GAP_TICKS     (2),
    .TIMEOUT_TICKS (3)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int song[15] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2};
  int sb_q[$];

  function automatic logic [7:0] led_of(input int n);
    logic [7:0] one;
    one = 8'd1;
    if (n == 0) return 8'd0;
    return one << (n - 1);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_once();
    bus.TICK = 1'b1;
    step();
    bus.TICK = 1'b0;
    step();
  endtask

  task automatic start_song(input logic mode);
    bus.MODE  = mode;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; bus.START = 1'b0; bus.MODE = 1'b0; bus.TICK = 1'b0; bus.key_note = 4'd0;
    step(); step();
    RESET = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL reset_err: got %0d want 0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.tone_note !== 4'd0) $display("FAIL reset_tone: got %0d want 0", bus.tone_note); else n_pass++;
    n_checks++; if (bus.Led !== 8'd0) $display("FAIL reset_led: got %b want 0", bus.Led); else n_pass++;
    n_checks++; if (bus.expect_note !== 4'd0) $display("FAIL reset_expect: got %0d want 0", bus.expect_note); else n_pass++;
    // TICK in IDLE does nothing
    tick_once();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_tick_busy: got %0b want 0", bus.busy); else n_pass++;
  endtask

  // Plays all 15 notes correctly; checks expect/Led/tone at every step.
  task automatic play_tutor_song(input string tag);
    int e;
    for (int i = 0; i < 15; i++) begin
      n_checks++; if (bus.expect_note !== 4'(song[i])) $display("FAIL %s_present_%0d: got %0d want %0d", tag, i, bus.expect_note, song[i]); else n_pass++;
      n_checks++; if (bus.Led !== led_of(song[i])) $display("FAIL %s_led_%0d: got %b want %b", tag, i, bus.Led, led_of(song[i])); else n_pass++;
      n_checks++; if (bus.tone_note !== 4'd0) $display("FAIL %s_tone_%0d: got %0d want 0", tag, i, bus.tone_note); else n_pass++;
      bus.key_note = 4'(song[i]);
      sb_q.push_back(song[i]);
      step();
      e = sb_q.pop_front();
      n_checks++; if (bus.expect_note !== 4'(e)) $display("FAIL %s_release_%0d: got %0d want %0d", tag, i, bus.expect_note, e); else n_pass++;
      bus.key_note = 4'd0;
      sb_q.push_back((i < 14) ? song[i+1] : 0);
      step();
      e = sb_q.pop_front();
      n_checks++; if (bus.expect_note !== 4'(e)) $display("FAIL %s_next_%0d: got %0d want %0d", tag, i, bus.expect_note, e); else n_pass++;
    end
  endtask

  task automatic test_tutor_full();
    start_song(1'b0);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL tutor_busy: got %0b want 1", bus.busy); else n_pass++;
    play_tutor_song("tutor");
    n_checks++; if (bus.done !== 1'b1) $display("FAIL tutor_done: got %0b want 1", bus.done); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL tutor_done_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL tutor_err: got %0d want 0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.Led !== 8'd0) $display("FAIL tutor_done_led: got %b want 0", bus.Led); else n_pass++;
    step(); step();
    n_checks++; if (bus.done !== 1'b1) $display("FAIL tutor_done_hold: got %0b want 1", bus.done); else n_pass++;
  endtask

  task automatic test_wrong_note();
    do_reset();
    start_song(1'b0);
    bus.key_note = 4'd5;
    step();
    n_checks++; if (bus.err_cnt !== 8'd1) $display("FAIL wrong_err: got %0d want 1", bus.err_cnt); else n_pass++;
    // holding the key, plus a START while busy, must change nothing
    bus.MODE = 1'b1; bus.START = 1'b1; step(); bus.START = 1'b0;
    step(); step(); step();
    n_checks++; if (bus.err_cnt !== 8'd1) $display("FAIL wrong_hold_err: got %0d want 1", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.tone_note !== 4'd0) $display("FAIL busy_start_tone: got %0d want 0", bus.tone_note); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL busy_start_busy: got %0b want 1", bus.busy); else n_pass++;
    bus.key_note = 4'd0; step();
    n_checks++; if (bus.expect_note !== 4'd3) $display("FAIL wrong_idx0: got %0d want 3", bus.expect_note); else n_pass++;
    bus.key_note = 4'd3; step();
    n_checks++; if (bus.expect_note !== 4'd3) $display("FAIL wrong_release_idx0: got %0d want 3", bus.expect_note); else n_pass++;
    bus.key_note = 4'd0; step();
    n_checks++; if (bus.Led !== 8'b00000100) $display("FAIL wrong_led_idx1: got %b want 00000100", bus.Led); else n_pass++;
    n_checks++; if (bus.err_cnt !== 8'd1) $display("FAIL wrong_err_after: got %0d want 1", bus.err_cnt); else n_pass++;
    bus.key_note = 4'd3; step(); bus.key_note = 4'd0; step();
    n_checks++; if (bus.expect_note !== 4'd4) $display("FAIL wrong_idx2: got %0d want 4", bus.expect_note); else n_pass++;
  endtask

  task automatic test_autoplay();
    int e;
    do_reset();
    start_song(1'b1);
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < 4; k++) sb_q.push_back(song[i]);
      for (int k = 0; k < 2; k++) sb_q.push_back(0);
    end
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL auto_busy: got %0b want 1", bus.busy); else n_pass++;
    for (int t = 0; t < 90; t++) begin
      bus.TICK = 1'b1;
      e = sb_q.pop_front();
      n_checks++; if (bus.tone_note !== 4'(e)) $display("FAIL auto_tone_tick%0d: got %0d want %0d", t, bus.tone_note, e); else n_pass++;
      step();
      bus.TICK = 1'b0;
      step();
    end
    n_checks++; if (bus.done !== 1'b1) $display("FAIL auto_done: got %0b want 1", bus.done); else n_pass++;
    n_checks++; if (bus.tone_note !== 4'd0) $display("FAIL auto_done_tone: got %0d want 0", bus.tone_note); else n_pass++;
    tick_once();
    n_checks++; if (bus.done !== 1'b1) $display("FAIL auto_done_tick: got %0b want 1", bus.done); else n_pass++;
  endtask

  task automatic test_reset_mid_song();
    do_reset();
    start_song(1'b1);
    for (int t = 0; t < 36; t++) tick_once();
    n_checks++; if (bus.tone_note !== 4'(song[6])) $display("FAIL mid_tone_idx6: got %0d want %0d", bus.tone_note, song[6]); else n_pass++;
    RESET = 1'b1; bus.START = 1'b1; bus.MODE = 1'b1;
    step();
    RESET = 1'b0; bus.START = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_reset_busy: got %0b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.tone_note !== 4'd0) $display("FAIL mid_reset_tone: got %0d want 0", bus.tone_note); else n_pass++;
    n_checks++; if (bus.Led !== 8'd0) $display("FAIL mid_reset_led: got %b want 0", bus.Led); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL mid_reset_done: got %0b want 0", bus.done); else n_pass++;
    step();
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_reset_start_ignored: got %0b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_song(1'b0);
    bus.key_note = 4'd8; step(); bus.key_note = 4'd0; step();
    play_tutor_song("b2b");
    n_checks++; if (bus.err_cnt !== 8'd1) $display("FAIL b2b_err: got %0d want 1", bus.err_cnt); else n_pass++;
    start_song(1'b1);
    n_checks++; if (bus.done !== 1'b0) $display("FAIL b2b_done: got %0b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL b2b_err_clear: got %0d want 0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.tone_note !== 4'd3) $display("FAIL b2b_tone: got %0d want 3", bus.tone_note); else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    start_song(1'b0);
    for (int n = 1; n <= 20; n++) begin
      bus.key_note = 4'd8; step(); bus.key_note = 4'd0; step();
    end
    n_checks++; if (bus.err_cnt !== 8'd20) $display("FAIL sat_err20: got %0d want 20", bus.err_cnt); else n_pass++;
    for (int n = 21; n <= 320; n++) begin
      bus.key_note = 4'd8; step(); bus.key_note = 4'd0; step();
      if (n == 255) begin
        n_checks++; if (bus.err_cnt !== 8'd255) $display("FAIL sat_err255: got %0d want 255", bus.err_cnt); else n_pass++;
      end
    end
    n_checks++; if (bus.err_cnt !== 8'd255) $display("FAIL sat_err_hold: got %0d want 255", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.expect_note !== 4'd3) $display("FAIL sat_idx0: got %0d want 3", bus.expect_note); else n_pass++;
  endtask

`ifdef PRACTICE_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start_song(1'b0);
    tick_once(); tick_once();
    n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL to_err_early: got %0d want 0", bus.err_cnt); else n_pass++;
    tick_once();
    n_checks++; if (bus.err_cnt !== 8'd1) $display("FAIL to_err1: got %0d want 1", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.Led !== 8'b00000100) $display("FAIL to_led_idx1: got %b want 00000100", bus.Led); else n_pass++;
    tick_once(); tick_once(); tick_once();
    n_checks++; if (bus.expect_note !== 4'd4) $display("FAIL to_idx2: got %0d want 4", bus.expect_note); else n_pass++;
    tick_once(); tick_once();
    bus.TICK = 1'b1; bus.key_note = 4'd4; step();
    bus.TICK = 1'b0; bus.key_note = 4'd0; step();
    n_checks++; if (bus.err_cnt !== 8'd2) $display("FAIL to_key_priority_err: got %0d want 2", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.expect_note !== 4'd5) $display("FAIL to_key_priority_idx3: got %0d want 5", bus.expect_note); else n_pass++;
  endtask
`else
  task automatic test_timeout();
    do_reset();
    start_song(1'b0);
    for (int t = 0; t < 8; t++) tick_once();
    n_checks++; if (bus.err_cnt !== 8'd0) $display("FAIL no_to_err: got %0d want 0", bus.err_cnt); else n_pass++;
    bus.key_note = 4'd3; step(); bus.key_note = 4'd0; step();
    bus.key_note = 4'd3; step(); bus.key_note = 4'd0; step();
    n_checks++; if (bus.expect_note !== 4'd4) $display("FAIL no_to_idx2: got %0d want 4", bus.expect_note); else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET        = 1'b1;
    bus.START    = 1'b0;
    bus.MODE     = 1'b0;
    bus.TICK     = 1'b0;
    bus.key_note = 4'd0;
    test_reset();
    test_tutor_full();
    test_wrong_note();
    test_autoplay();
    test_reset_mid_song();
    test_back_to_back();
    test_saturation();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
